// File: rtl/trap_pkg.sv
// ---------------------------------------------------------------------------
// trap_pkg
// Shared definitions for the trap controller slice: mcause codes, FSM state
// encoding and privilege encodings.
// Optional feature macro (used by trap_controller): TRAP_TVAL_EN
// ---------------------------------------------------------------------------
package trap_pkg;

    localparam logic [31:0] CAUSE_FETCH_MISALIGNED = 32'd0;
    localparam logic [31:0] CAUSE_ILLEGAL          = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT       = 32'd3;
    localparam logic [31:0] CAUSE_LOAD_MISALIGNED  = 32'd4;
    localparam logic [31:0] CAUSE_STORE_MISALIGNED = 32'd6;
    localparam logic [31:0] CAUSE_ECALL_BASE       = 32'd8;

    localparam logic [1:0] PRIV_U = 2'b00;
    localparam logic [1:0] PRIV_M = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_RAISE         = 2'd1,
        ST_DRAIN         = 2'd2,
        ST_WAIT_REDIRECT = 2'd3
    } trap_state_t;

endpackage

// File: rtl/trap_priority_encoder.sv
// ---------------------------------------------------------------------------
// trap_priority_encoder
// Purely combinational selection of the oldest, highest-priority exception.
// Memory stage beats decode stage beats fetch stage.
// Ports:
//   i_current_privilege     privilege of the decode-stage instruction
//   i_fetch_misaligned      fetch flag,  i_fetch_pc   its PC
//   i_illegal_instr, i_csr_violation, i_ecall, i_ebreak  decode flags,
//   i_decode_pc             decode PC
//   i_load_misaligned, i_store_misaligned  memory flags, i_mem_pc memory PC
//   o_any_exc               at least one flag is set
//   o_sel_pc / o_sel_cause  PC and mcause of the winner
// ---------------------------------------------------------------------------
module trap_priority_encoder
    import trap_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_current_privilege,
    input  logic            i_fetch_misaligned,
    input  logic [XLEN-1:0] i_fetch_pc,
    input  logic            i_illegal_instr,
    input  logic            i_csr_violation,
    input  logic            i_ecall,
    input  logic            i_ebreak,
    input  logic [XLEN-1:0] i_decode_pc,
    input  logic            i_load_misaligned,
    input  logic            i_store_misaligned,
    input  logic [XLEN-1:0] i_mem_pc,
    output logic            o_any_exc,
    output logic [XLEN-1:0] o_sel_pc,
    output logic [31:0]     o_sel_cause
);

    assign o_any_exc = i_load_misaligned | i_store_misaligned | i_illegal_instr |
                       i_csr_violation | i_ebreak | i_ecall | i_fetch_misaligned;

    always_comb begin
        o_sel_pc    = '0;
        o_sel_cause = '0;
        if (i_load_misaligned) begin
            o_sel_pc    = i_mem_pc;
            o_sel_cause = CAUSE_LOAD_MISALIGNED;
        end else if (i_store_misaligned) begin
            o_sel_pc    = i_mem_pc;
            o_sel_cause = CAUSE_STORE_MISALIGNED;
        end else if (i_illegal_instr || i_csr_violation) begin
            o_sel_pc    = i_decode_pc;
            o_sel_cause = CAUSE_ILLEGAL;
        end else if (i_ebreak) begin
            o_sel_pc    = i_decode_pc;
            o_sel_cause = CAUSE_BREAKPOINT;
        end else if (i_ecall) begin
            // ECALL cause encodes the caller's privilege: 8 from U, 11 from M.
            o_sel_pc    = i_decode_pc;
            o_sel_cause = CAUSE_ECALL_BASE + {30'd0, i_current_privilege};
        end else if (i_fetch_misaligned) begin
            o_sel_pc    = i_fetch_pc;
            o_sel_cause = CAUSE_FETCH_MISALIGNED;
        end
    end

endmodule

// File: rtl/trap_controller.sv
// ---------------------------------------------------------------------------
// trap_controller
// Collects synchronous exceptions, hands the winner to the CSR unit as a
// one-cycle pulse, flushes the pipeline and holds fetch until the PC unit
// acknowledges the redirect.
//
//   state            | meaning
//   -----------------+---------------------------------------------------
//   ST_IDLE          | watching exception flags
//   ST_RAISE         | one-cycle trap pulse to CSR unit, flush starts
//   ST_DRAIN         | flush held for FLUSH_CYCLES cycles
//   ST_WAIT_REDIRECT | flush released, fetch held until redirect_ack
//
// Ports:
//   i_clk, i_reset (async, active-high)
//   exception flags/PCs from fetch, decode and memory stages
//   i_redirect_ack   PC unit has loaded the trap vector
//   o_trap_sources   one-cycle trap request
//   o_trap_instr_pc  PC of faulting instruction (held until next capture)
//   o_trap_cause     mcause (held until next capture)
//   o_flush_pipeline, o_stall_fetch, o_busy
// Optional feature macro TRAP_TVAL_EN adds i_fetch_addr, i_mem_addr,
// i_decode_instr and o_trap_tval (faulting address / instruction bits).
// ---------------------------------------------------------------------------
module trap_controller
    import trap_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [1:0]      i_current_privilege,
    input  logic            i_fetch_misaligned,
    input  logic [XLEN-1:0] i_fetch_pc,
    input  logic            i_illegal_instr,
    input  logic            i_csr_violation,
    input  logic            i_ecall,
    input  logic            i_ebreak,
    input  logic [XLEN-1:0] i_decode_pc,
    input  logic            i_load_misaligned,
    input  logic            i_store_misaligned,
    input  logic [XLEN-1:0] i_mem_pc,
    input  logic            i_redirect_ack,
    output logic            o_trap_sources,
    output logic [XLEN-1:0] o_trap_instr_pc,
    output logic [31:0]     o_trap_cause,
    output logic            o_flush_pipeline,
    output logic            o_stall_fetch,
    output logic            o_busy
`ifdef TRAP_TVAL_EN
    ,
    input  logic [XLEN-1:0] i_fetch_addr,
    input  logic [XLEN-1:0] i_mem_addr,
    input  logic [31:0]     i_decode_instr,
    output logic [XLEN-1:0] o_trap_tval
`endif
);

    localparam logic [2:0] LP_FLUSH_LOAD = 3'(FLUSH_CYCLES);

    trap_state_t     r_state;
    trap_state_t     w_next_state;
    logic [2:0]      r_drain_cnt;
    logic [XLEN-1:0] r_trap_pc;
    logic [31:0]     r_trap_cause;
    logic            w_any_exc;
    logic [XLEN-1:0] w_sel_pc;
    logic [31:0]     w_sel_cause;
    logic            w_capture;

    trap_priority_encoder #(.XLEN(XLEN)) u_prio (
        .i_current_privilege (i_current_privilege),
        .i_fetch_misaligned  (i_fetch_misaligned),
        .i_fetch_pc          (i_fetch_pc),
        .i_illegal_instr     (i_illegal_instr),
        .i_csr_violation     (i_csr_violation),
        .i_ecall             (i_ecall),
        .i_ebreak            (i_ebreak),
        .i_decode_pc         (i_decode_pc),
        .i_load_misaligned   (i_load_misaligned),
        .i_store_misaligned  (i_store_misaligned),
        .i_mem_pc            (i_mem_pc),
        .o_any_exc           (w_any_exc),
        .o_sel_pc            (w_sel_pc),
        .o_sel_cause         (w_sel_cause)
    );

    // Flags are only honoured in IDLE; anything later belongs to squashed work.
    assign w_capture = (r_state == ST_IDLE) && w_any_exc;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:          if (w_any_exc)           w_next_state = ST_RAISE;
            ST_RAISE:                                  w_next_state = ST_DRAIN;
            ST_DRAIN:         if (r_drain_cnt == 3'd1) w_next_state = ST_WAIT_REDIRECT;
            ST_WAIT_REDIRECT: if (i_redirect_ack)      w_next_state = ST_IDLE;
            default:                                   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        o_trap_sources   = 1'b0;
        o_flush_pipeline = 1'b0;
        o_stall_fetch    = 1'b0;
        o_busy           = 1'b0;
        case (r_state)
            ST_RAISE: begin
                o_trap_sources   = 1'b1;
                o_flush_pipeline = 1'b1;
                o_stall_fetch    = 1'b1;
                o_busy           = 1'b1;
            end
            ST_DRAIN: begin
                o_flush_pipeline = 1'b1;
                o_stall_fetch    = 1'b1;
                o_busy           = 1'b1;
            end
            ST_WAIT_REDIRECT: begin
                o_stall_fetch    = 1'b1;
                o_busy           = 1'b1;
            end
            default: ;
        endcase
    end

    // Drain down-counter: loaded during RAISE, DRAIN exits when it reads 1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_drain_cnt <= '0;
        end else if (r_state == ST_RAISE) begin
            r_drain_cnt <= LP_FLUSH_LOAD;
        end else if (r_state == ST_DRAIN) begin
            r_drain_cnt <= r_drain_cnt - 3'd1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_trap_pc    <= '0;
            r_trap_cause <= '0;
        end else if (w_capture) begin
            r_trap_pc    <= w_sel_pc;
            r_trap_cause <= w_sel_cause;
        end
    end

    assign o_trap_instr_pc = r_trap_pc;
    assign o_trap_cause    = r_trap_cause;

`ifdef TRAP_TVAL_EN
    logic [XLEN-1:0] r_trap_tval;
    logic [XLEN-1:0] w_sel_tval;

    always_comb begin
        w_sel_tval = '0;
        case (w_sel_cause)
            CAUSE_FETCH_MISALIGNED:                        w_sel_tval = i_fetch_addr;
            CAUSE_LOAD_MISALIGNED, CAUSE_STORE_MISALIGNED: w_sel_tval = i_mem_addr;
            CAUSE_ILLEGAL:                                 w_sel_tval = XLEN'(i_decode_instr);
            default:                                       w_sel_tval = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_trap_tval <= '0;
        end else if (w_capture) begin
            r_trap_tval <= w_sel_tval;
        end
    end

    assign o_trap_tval = r_trap_tval;
`endif

    // A zero load would wrap the 3-bit counter and stretch DRAIN to 8 cycles.
    a_flush_cycles_legal: assert property (@(posedge i_clk) disable iff (i_reset)
        (FLUSH_CYCLES >= 1) && (FLUSH_CYCLES <= 7));

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

    localparam int XLEN  = 32;
    localparam int FLUSH = 2;

    // flag vector order: {load, store, illegal, csr, ebreak, ecall, fetch}
    localparam logic [6:0] F_LOAD  = 7'b1000000;
    localparam logic [6:0] F_STORE = 7'b0100000;
    localparam logic [6:0] F_ILL   = 7'b0010000;
    localparam logic [6:0] F_CSR   = 7'b0001000;
    localparam logic [6:0] F_EBRK  = 7'b0000100;
    localparam logic [6:0] F_ECALL = 7'b0000010;
    localparam logic [6:0] F_FETCH = 7'b0000001;

    localparam logic [31:0] FETCH_ADDR = 32'h0000_1001;
    localparam logic [31:0] MEM_ADDR   = 32'h0000_2003;
    localparam logic [31:0] INSTR_BITS = 32'hDEAD_BEEF;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      current_privilege;
    logic            fetch_misaligned, illegal_instr, csr_violation, ecall, ebreak;
    logic            load_misaligned, store_misaligned, redirect_ack;
    logic [XLEN-1:0] fetch_pc, decode_pc, mem_pc;
    logic            trap_sources, flush_pipeline, stall_fetch, busy;
    logic [XLEN-1:0] trap_instr_pc;
    logic [31:0]     trap_cause;
`ifdef TRAP_TVAL_EN
    logic [XLEN-1:0] fetch_addr, mem_addr, trap_tval;
    logic [31:0]     decode_instr;
    assign fetch_addr   = FETCH_ADDR;
    assign mem_addr     = MEM_ADDR;
    assign decode_instr = INSTR_BITS;
`endif

    always #5 clk = ~clk;

    trap_controller #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH)) dut (
        .i_clk               (clk),
        .i_reset             (reset),
        .i_current_privilege (current_privilege),
        .i_fetch_misaligned  (fetch_misaligned),
        .i_fetch_pc          (fetch_pc),
        .i_illegal_instr     (illegal_instr),
        .i_csr_violation     (csr_violation),
        .i_ecall             (ecall),
        .i_ebreak            (ebreak),
        .i_decode_pc         (decode_pc),
        .i_load_misaligned   (load_misaligned),
        .i_store_misaligned  (store_misaligned),
        .i_mem_pc            (mem_pc),
        .i_redirect_ack      (redirect_ack),
        .o_trap_sources      (trap_sources),
        .o_trap_instr_pc     (trap_instr_pc),
        .o_trap_cause        (trap_cause),
        .o_flush_pipeline    (flush_pipeline),
        .o_stall_fetch       (stall_fetch),
        .o_busy              (busy)
`ifdef TRAP_TVAL_EN
        ,
        .i_fetch_addr        (fetch_addr),
        .i_mem_addr          (mem_addr),
        .i_decode_instr      (decode_instr),
        .o_trap_tval         (trap_tval)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] tval;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pulses = 0;
    int   n_pushed = 0;
    logic prev_ts  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every trap pulse must match the oldest pushed entry.
    always @(negedge clk) begin
        if (trap_sources === 1'b1) begin
            n_pulses++;
            if (prev_ts) chk("ts_consecutive", 64'd1, 64'd0);
            if (sb_q.size() == 0) begin
                chk("ts_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("trap_pc", 64'(trap_instr_pc), 64'(mon_e.pc));
                chk("trap_cause", 64'(trap_cause), 64'(mon_e.cause));
`ifdef TRAP_TVAL_EN
                chk("trap_tval", 64'(trap_tval), 64'(mon_e.tval));
`endif
            end
        end
        prev_ts = (trap_sources === 1'b1);
    end

    task automatic clr_flags();
        {load_misaligned, store_misaligned, illegal_instr, csr_violation,
         ebreak, ecall, fetch_misaligned} = 7'b0;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] cause, input logic [31:0] tval);
        exp_t e;
        e.pc = pc; e.cause = cause; e.tval = tval;
        sb_q.push_back(e);
        n_pushed++;
    endtask

    task automatic fire(input logic [6:0] flags, input logic [1:0] priv,
                        input logic [31:0] fpc, input logic [31:0] dpc, input logic [31:0] mpc,
                        input logic [31:0] exp_pc, input logic [31:0] exp_cause,
                        input logic [31:0] exp_tval, input int ack_delay, input bit noise);
        int flen;
        @(posedge clk); #1;
        {load_misaligned, store_misaligned, illegal_instr, csr_violation,
         ebreak, ecall, fetch_misaligned} = flags;
        current_privilege = priv;
        fetch_pc = fpc; decode_pc = dpc; mem_pc = mpc;
        push_exp(exp_pc, exp_cause, exp_tval);
        @(posedge clk); #1;
        clr_flags();
        chk("raise_ts", 64'(trap_sources), 64'd1);
        chk("raise_stall", 64'(stall_fetch), 64'd1);
        flen = 1;
        for (int i = 0; i < 20; i++) begin
            if (noise) begin
                ebreak = 1'b1; decode_pc = 32'h999; redirect_ack = 1'b1;
            end
            @(posedge clk); #1;
            if (!flush_pipeline) break;
            flen++;
        end
        clr_flags();
        redirect_ack = 1'b0;
        chk("flush_len", 64'(flen), 64'(1 + FLUSH));
        chk("wait_busy", 64'(busy), 64'd1);
        chk("hold_cause", 64'(trap_cause), 64'(exp_cause));
        repeat (ack_delay) @(posedge clk);
        #1;
        chk("wait_stall", 64'(stall_fetch), 64'd1);
        redirect_ack = 1'b1;
        @(posedge clk); #1;
        redirect_ack = 1'b0;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_stall", 64'(stall_fetch), 64'd0);
        chk("idle_pc_held", 64'(trap_instr_pc), 64'(exp_pc));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        clr_flags();
        redirect_ack = 1'b0;
        current_privilege = 2'b00;
        fetch_pc = '0; decode_pc = '0; mem_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_stall", 64'(stall_fetch), 64'd0);
        chk("rst_cause", 64'(trap_cause), 64'd0);
        reset = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("idle_noflags_busy", 64'(busy), 64'd0);

        fire(F_ILL, 2'b00, 32'h0, 32'h100, 32'h0, 32'h100, 32'd2, INSTR_BITS, 0, 0);
        fire(F_LOAD | F_ECALL | F_FETCH, 2'b00, 32'h208, 32'h204, 32'h200,
             32'h200, 32'd4, MEM_ADDR, 1, 0);
        fire(F_ECALL, 2'b11, 32'h0, 32'h300, 32'h0, 32'h300, 32'd11, 32'h0, 0, 0);
        fire(F_ECALL, 2'b00, 32'h0, 32'h304, 32'h0, 32'h304, 32'd8, 32'h0, 0, 0);
        fire(F_EBRK, 2'b00, 32'h0, 32'h400, 32'h0, 32'h400, 32'd3, 32'h0, 10, 1);
        fire(F_STORE | F_ILL, 2'b00, 32'h0, 32'h504, 32'h500, 32'h500, 32'd6, MEM_ADDR, 2, 0);
        fire(F_CSR, 2'b11, 32'h0, 32'h600, 32'h0, 32'h600, 32'd2, INSTR_BITS, 0, 0);
        fire(F_EBRK | F_ECALL, 2'b11, 32'h0, 32'h700, 32'h0, 32'h700, 32'd3, 32'h0, 0, 1);
        fire(F_FETCH, 2'b00, 32'h802, 32'h0, 32'h0, 32'h802, 32'd0, FETCH_ADDR, 3, 0);
        fire(F_ILL | F_EBRK | F_FETCH, 2'b00, 32'h904, 32'h900, 32'h0,
             32'h900, 32'd2, INSTR_BITS, 0, 0);

        // Asynchronous reset in the middle of DRAIN
        @(posedge clk); #1;
        illegal_instr = 1'b1; decode_pc = 32'hA00;
        push_exp(32'hA00, 32'd2, INSTR_BITS);
        @(posedge clk); #1;
        clr_flags();
        @(posedge clk); #1;
        chk("pre_rst_flush", 64'(flush_pipeline), 64'd1);
        #2 reset = 1'b1;
        #1;
        chk("arst_ts", 64'(trap_sources), 64'd0);
        chk("arst_pc", 64'(trap_instr_pc), 64'd0);
        chk("arst_cause", 64'(trap_cause), 64'd0);
        chk("arst_flush", 64'(flush_pipeline), 64'd0);
        chk("arst_stall", 64'(stall_fetch), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        fire(F_STORE, 2'b00, 32'h0, 32'h0, 32'hB00, 32'hB00, 32'd6, MEM_ADDR, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb_q.size()), 64'd0);
        chk("pulse_count", 64'(n_pulses), 64'(n_pushed));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
